// File: rtl/modport_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package modport_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_e;

    localparam int MAX_REQ = 16;
    localparam int MAX_IDW = 4;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDW-1:0] idx);
        logic [MAX_REQ-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/modport_rr_arbiter_if.sv
// Shared single-bit bus: the arbiter drives signal_b and samples signal_a.
interface my_if;
    logic signal_a;
    logic signal_b;

    modport mp    (input signal_a, output signal_b);
    modport slave (output signal_a, input signal_b);
endinterface

// File: rtl/modport_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     pick,
    output logic               pick_valid
);

    localparam int SW = IDW + 1;

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDW-1:0]       enc;
    logic [SW-1:0]        sum;

    always_comb begin
        // Doubling the vector turns the rotate into a plain right shift.
        dbl = {req, req} >> ptr;
        rot = dbl[NUM_REQ-1:0];
        enc = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) enc = IDW'(i);
        end
        sum = {1'b0, enc} + {1'b0, ptr};
        if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
        pick       = sum[IDW-1:0];
        pick_valid = |req;
    end

endmodule

// File: rtl/modport_rr_arbiter.sv
// Round-robin owner of one shared my_if bus with hold timeout and a turnaround cycle.
module modport_rr_arbiter
    import modport_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int HOLD_MAX = 8,
    localparam int IDW      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    my_if.mp                   bus_mp,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] rsp_a,
    output logic [IDW-1:0]     owner_id,
    output logic               busy,
    output logic               timeout_pulse
);

    localparam int CW = $clog2(HOLD_MAX + 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               tmo_q, tmo_d;

    logic [IDW-1:0]     pick;
    logic               pick_valid;
    logic [MAX_REQ-1:0] oh_pick;
    logic [IDW-1:0]     ptr_nxt;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        oh_pick = onehot(MAX_IDW'(pick));
        ptr_nxt = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        case (state_q)
            IDLE, RELEASE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    gnt_d   = oh_pick[NUM_REQ-1:0];
                    owner_d = pick;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            GRANT: begin
                // A drop wins over the limit so a simultaneous drop never flags a timeout.
                if (!req[owner_q]) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    ptr_d   = ptr_nxt;
                end else if (cnt_q == CW'(HOLD_MAX - 1)) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    ptr_d   = ptr_nxt;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign gnt           = gnt_q;
    assign owner_id      = owner_q;
    assign busy          = (state_q == GRANT);
    assign timeout_pulse = tmo_q;

    assign bus_mp.signal_b = busy & req_data[owner_q];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
        assign rsp_a[g] = busy & (owner_q == IDW'(g)) & bus_mp.signal_a;
    end

endmodule

// File: doc/modport_rr_arbiter.md
Name: modport_rr_arbiter

Overview:
- Round-robin arbiter that shares one `my_if` bus, through its `mp` modport, among NUM_REQ requesters.
- Per cycle, exactly one requester (or none) owns the bus:
  - the owner's data drives `signal_b`;
  - `signal_a` is returned only to the owner.
- Grant ownership is bounded by a hold timeout.
- A one-cycle turnaround separates consecutive owners.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- HOLD_MAX, 8, maximum consecutive GRANT cycles per ownership (>=1).
- IDW, $clog2(NUM_REQ), width of owner index (derived; not overridable).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bus_mp  interface  my_if.mp  shared bus; arbiter reads `signal_a` and drives `signal_b`.
- req  input  NUM_REQ  per-requester request, level-sensitive.
- req_data  input  NUM_REQ  per-requester value for `signal_b`.
- gnt  output  NUM_REQ  registered one-hot grant.
- rsp_a  output  NUM_REQ  `bus_mp.signal_a` routed to the owner bit; other bits 0.
- owner_id  output  IDW  index of current owner; valid while busy.
- busy  output  1  high in GRANT state.
- timeout_pulse  output  1  one-cycle pulse when an owner is forced off.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - state = IDLE;
  - gnt = 0, owner_id = 0, busy = 0, timeout_pulse = 0;
  - priority pointer ptr = 0, hold counter = 0.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req != 0, pick the first set bit searching from ptr upward with wrap.
  - Next edge: GRANT, gnt = onehot(pick), owner_id = pick, hold counter = 0.
- GRANT:
  - Counter increments each cycle.
  - If req[owner_id] = 0 at an edge: go to RELEASE, gnt = 0.
  - Else if counter = HOLD_MAX-1: go to RELEASE, gnt = 0, timeout_pulse = 1 for the RELEASE cycle only.
  - Else stay in GRANT.
- RELEASE (turnaround cycle):
  - ptr = (owner_id + 1) mod NUM_REQ, updated on entry.
  - Arbitrate exactly as IDLE using the new ptr; go to GRANT if any req, else IDLE.
- Latency:
  - Request seen in IDLE at edge N → gnt high after edge N.
  - Minimum gap between owners: 1 cycle with gnt = 0.
- Datapath (combinational from registered gnt):
  - `signal_b` = req_data[owner_id] when busy, else 0.
  - rsp_a[owner_id] = `signal_a` when busy; all other bits 0.
- Boundary cases:
  - Sole requester that times out regains the grant after one RELEASE cycle.
  - HOLD_MAX = 1 gives one GRANT cycle per ownership.
  - Pointer wraps from NUM_REQ-1 to 0.
  - req bits of non-owners changing during GRANT have no effect.
  - Owner drop and timeout on the same edge: treated as a normal release, no timeout_pulse.
  - Reset mid-GRANT: outputs clear immediately, asynchronously, and `signal_b` = 0.
- Invariants:
  - gnt is always 0 or one-hot.
  - busy = |gnt.

Decomposition:
- Package `modport_arb_pkg`: state enum `arb_state_e` {IDLE, GRANT, RELEASE}; function `onehot(idx)`.
- Sub-module `rr_pick`: combinational.
  - Inputs: req, ptr.
  - Outputs: pick index, pick_valid.
  - Rotate, priority-encode, un-rotate.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles → gnt=0, busy=0, `signal_b`=0, timeout_pulse=0.
- req=4'b0100 with req_data[2]=1 → gnt=4'b0100 after 1 edge; owner_id=2; `signal_b`=1. Drop req[2] → one cycle gnt=0, then IDLE.
- req=4'b1111 held, HOLD_MAX=8 → grants in order 0,1,2,3,0; each lasts 8 cycles and is followed by one RELEASE cycle with timeout_pulse=1.
- Owner 3 releases while req=4'b0011 → ptr wraps to 0; next gnt=4'b0001.
- Drive `signal_a`=1 with owner 1 → rsp_a=4'b0010. With no owner → rsp_a=4'b0000.
- Assert rst_n=0 mid-GRANT, asynchronously between edges → gnt, busy and `signal_b` go 0 before the next edge. After release, arbitration restarts with ptr=0.
